// File: rtl/logic_pipe.sv
// Registered bitwise logic unit: eight selectable two-operand operations with a
// valid/ready output stage and a multi-beat accumulate (reduction) mode.
module logic_pipe #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             Accum,
    input  logic             Last,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [CNTW-1:0]  Count
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_p0, acc_d;
    logic [CNTW-1:0]  cnt_p0, cnt_d;

    logic             vld_p1;
    logic [WIDTH-1:0] res_p1;
    logic             zero_p1;
    logic [CNTW-1:0]  cnt_p1;

    logic             accept;
    logic             emit;
    logic [WIDTH-1:0] res_d;
    logic [CNTW-1:0]  cnto_d;
    logic [WIDTH-1:0] fold;
    logic [CNTW-1:0]  cnt_inc;

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~(x | y);
            3'd4:    r = x & ~y;
            3'd5:    r = ~(x & y);
            3'd6:    r = ~(x ^ y);
            default: r = x;
        endcase
        return r;
    endfunction

    // Beat counter sticks at all-ones instead of wrapping on very long bursts.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    // Non-emitting beats also need a free output slot, keeping acceptance uniform.
    assign InReady = ~vld_p1 | OutReady;
    assign accept  = InValid & InReady;
    assign fold    = logic_op(Op, acc_p0, A);
    assign cnt_inc = sat_inc(cnt_p0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_p0;
        cnt_d   = cnt_p0;
        emit    = 1'b0;
        res_d   = res_p1;
        cnto_d  = cnt_p1;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!Accum) begin
                        emit   = 1'b1;
                        res_d  = logic_op(Op, A, B);
                        cnto_d = CNTW'(1);
                    end else if (Last) begin
                        emit   = 1'b1;
                        res_d  = A;
                        cnto_d = CNTW'(1);
                    end else begin
                        acc_d   = A;
                        cnt_d   = CNTW'(1);
                        state_d = ACCUM;
                    end
                end
                default: begin
                    if (Last) begin
                        emit    = 1'b1;
                        res_d   = fold;
                        cnto_d  = cnt_inc;
                        state_d = IDLE;
                    end else begin
                        acc_d = fold;
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end
    end

    // Stage p0: accumulator and burst state
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            acc_p0  <= '0;
            cnt_p0  <= '0;
        end else begin
            state_q <= state_d;
            acc_p0  <= acc_d;
            cnt_p0  <= cnt_d;
        end
    end

    // Stage p1: output register, held while the consumer stalls
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_p1  <= 1'b0;
            res_p1  <= '0;
            zero_p1 <= 1'b1;
            cnt_p1  <= '0;
        end else if (emit) begin
            vld_p1  <= 1'b1;
            res_p1  <= res_d;
            zero_p1 <= (res_d == '0);
            cnt_p1  <= cnto_d;
        end else if (OutReady) begin
            vld_p1  <= 1'b0;
        end
    end

    assign OutValid = vld_p1;
    assign Result   = res_p1;
    assign Zero     = zero_p1;
    assign Count    = cnt_p1;

endmodule

// File: tb/tb_logic_pipe.sv
// Bench for logic_pipe: directed scenarios plus randomized traffic, checked
// against a burst-queue reference model evaluated at each clock.
module tb_logic_pipe;

    localparam int W    = 32;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst, InValid, InReady, Accum, Last, OutValid, OutReady, Zero;
    logic [W-1:0]  A, B, Result;
    logic [2:0]    Op;
    logic [CW-1:0] Count;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic         m_ov;
    logic [W-1:0] m_res;
    logic         m_zero;
    int           m_cnt;
    logic [W-1:0] bq_a[$];
    logic [2:0]   bq_op[$];

    logic [W-1:0] optab[8];

    always #5 Clk = ~Clk;

    logic_pipe #(.WIDTH(W), .CNTW(CW)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Op(Op), .Accum(Accum), .Last(Last),
        .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Zero(Zero), .Count(Count)
    );

    function automatic logic [W-1:0] fop(input logic [2:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x | y);
            3'd4: return x & ~y;
            3'd5: return ~(x & y);
            3'd6: return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_out(input logic [W-1:0] r, input int c);
        m_ov   = 1'b1;
        m_res  = r;
        m_zero = (r == '0);
        m_cnt  = (c > MAXC) ? MAXC : c;
    endtask

    // One clock: drive inputs, check InReady, advance the model, check outputs.
    task automatic step(input logic r, input logic iv, input logic ordy, input logic [2:0] op,
                        input logic acc, input logic last, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        logic         take;
        logic [W-1:0] f;
        Rst = r; InValid = iv; OutReady = ordy; Op = op; Accum = acc; Last = last;
        A = a; B = b;
        #1;
        chk("inready", {31'd0, InReady}, {31'd0, (!m_ov || ordy)});
        take = iv && (!m_ov || ordy);
        if (r) begin
            m_ov = 1'b0; m_res = '0; m_zero = 1'b1; m_cnt = 0;
            bq_a.delete(); bq_op.delete();
        end else begin
            if (ordy) m_ov = 1'b0;
            if (take) begin
                if (bq_a.size() == 0 && !acc) begin
                    load_out(fop(op, a, b), 1);
                end else begin
                    bq_a.push_back(a);
                    bq_op.push_back(op);
                    if (last) begin
                        f = bq_a[0];
                        for (int i = 1; i < bq_a.size(); i++) f = fop(bq_op[i], f, bq_a[i]);
                        load_out(f, bq_a.size());
                        bq_a.delete(); bq_op.delete();
                    end
                end
            end
        end
        @(posedge Clk);
        #1;
        chk("outvalid", {31'd0, OutValid}, {31'd0, m_ov});
        chk("result", Result, m_res);
        chk("zero", {31'd0, Zero}, {31'd0, m_zero});
        chk("count", {30'd0, Count}, m_cnt);
    endtask

    initial begin
        Rst = 1'b1; InValid = 1'b0; OutReady = 1'b0; Op = '0; Accum = 1'b0; Last = 1'b0;
        A = '0; B = '0;
        m_ov = 1'b0; m_res = '0; m_zero = 1'b1; m_cnt = 0;
        optab[0] = 32'hF000F000; optab[1] = 32'hFFF0FFF0; optab[2] = 32'h0FF00FF0;
        optab[3] = 32'h000F000F; optab[4] = 32'h00F000F0; optab[5] = 32'h0FFF0FFF;
        optab[6] = 32'hF00FF00F; optab[7] = 32'hF0F0F0F0;
        @(posedge Clk);
        #1;

        // reset
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 32'h5, 32'h3);
        chk("rst_result", Result, 32'h0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        chk("rst_valid", {31'd0, OutValid}, 32'd0);

        // 4-bit AND truth table
        step(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("and00_zero", {31'd0, Zero}, 32'd1);
        step(0, 1, 1, 0, 0, 0, 32'hF, 32'h0);
        step(0, 1, 1, 0, 0, 0, 32'h0, 32'hF);
        step(0, 1, 1, 0, 0, 0, 32'hF, 32'hF);
        chk("andff", Result, 32'hF);
        chk("andff_cnt", {30'd0, Count}, 32'd1);

        // every op on fixed operands
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 3'(i), 0, 0, 32'hF0F0F0F0, 32'hFF00FF00);
            chk("optab", Result, optab[i]);
        end
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // backpressure: offered beat waits, then loads on the take edge
        step(0, 1, 1, 1, 0, 0, 32'h1, 32'h2);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 2, 0, 0, 32'h30, 32'h0C);
        chk("bp_hold", Result, 32'h3);
        step(0, 1, 1, 2, 0, 0, 32'h30, 32'h0C);
        chk("bp_take", Result, 32'h3C);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("bp_drain", {31'd0, OutValid}, 32'd0);

        // accumulate bursts
        step(0, 1, 1, 2, 1, 0, 32'h1, 32'hFF);
        step(0, 1, 1, 2, 0, 0, 32'h2, 32'hFF);
        step(0, 1, 1, 2, 0, 1, 32'h4, 32'hFF);
        chk("xor_burst", Result, 32'h7);
        chk("xor_cnt", {30'd0, Count}, 32'd3);
        step(0, 1, 1, 0, 1, 0, 32'hFF, 32'h0);
        step(0, 1, 1, 0, 1, 0, 32'h0F, 32'h0);
        step(0, 1, 1, 0, 1, 1, 32'h03, 32'h0);
        chk("and_burst", Result, 32'h03);
        step(0, 1, 1, 3, 1, 1, 32'h5, 32'h0);
        chk("single_burst", Result, 32'h5);
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // reset mid-burst
        step(0, 1, 1, 1, 1, 0, 32'h8, 32'h0);
        step(0, 1, 1, 1, 1, 0, 32'h10, 32'h0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 32'h1, 32'h2);
        chk("post_rst", Result, 32'h3);
        chk("post_rst_cnt", {30'd0, Count}, 32'd1);
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // counter saturation
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 1, (i == 5), 32'h1, 32'h0);
        chk("sat_cnt", {30'd0, Count}, 32'd3);
        chk("sat_res", Result, 32'h1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3),
                 $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
